// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and defaults for the issue-stage register scoreboard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_scoreboard_pkg;

  // Default geometry: 32 architectural registers, producers up to 8 cycles deep.
  localparam int SB_NREG            = 32;
  localparam int SB_RPORTS          = 2;
  localparam int SB_MAXLAT          = 8;
  localparam int FWD_WINDOW_DEFAULT = 2;

  localparam int SB_REGW = $clog2(SB_NREG);
  localparam int SB_LATW = $clog2(SB_MAXLAT + 1);

  // Register index and per-register countdown for the default geometry.
  typedef logic [SB_REGW-1:0] regbits_t;
  typedef logic [SB_LATW-1:0] latcnt_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Signal bundle for the scoreboard: sb side is the block, tb side drives it.
// Latency: n/a (wiring only).
// Backpressure: stall/issue_accept travel back to the issuing side.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG   = SB_NREG,
  parameter int RPORTS = SB_RPORTS,
  parameter int MAXLAT = SB_MAXLAT,
  localparam int RW    = $clog2(NREG),
  localparam int LATW  = $clog2(MAXLAT + 1)
) (
  input logic CLK
);

  logic                 RST;
  logic                 freeze;
  logic                 flush;
  logic                 issue_valid;
  logic                 issue_wen;
  logic [RW-1:0]        issue_wsel;
  logic [LATW-1:0]      issue_lat;
  logic [RPORTS*RW-1:0] rsel;
  logic [RPORTS-1:0]    ren;
  logic [RPORTS-1:0]    rport_hazard;
  logic [RPORTS-1:0]    rport_fwd;
  logic                 stall;
  logic                 issue_accept;
  logic                 busy;

  modport sb (
    input  CLK, RST, freeze, flush, issue_valid, issue_wen, issue_wsel, issue_lat, rsel, ren,
    output rport_hazard, rport_fwd, stall, issue_accept, busy
  );

  modport tb (
    input  CLK, rport_hazard, rport_fwd, stall, issue_accept, busy,
    output RST, freeze, flush, issue_valid, issue_wen, issue_wsel, issue_lat, rsel, ren
  );

endinterface

// File: rtl/hazard_scoreboard_entry.sv
// One register's countdown of cycles left until its pending write lands.
// Latency: count visible one cycle after load; decrements once per unheld cycle.
// Backpressure: hold freezes the count; clear wins over hold, hold over load.
module hazard_scoreboard_entry #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         hold,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d, cnt_q;

  // Next count: squash, freeze, new producer, else count down toward zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (hold) begin
      cnt_d = cnt_q;
    end else if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage scoreboard: per-register writeback countdowns, RAW/WAW detection, bypass select.
// Latency: all outputs combinational from current counts; an accepted write shows next cycle.
// Backpressure: stall on unforwardable RAW or WAW; freeze holds counts and blocks accept.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG   = SB_NREG,
  parameter int RPORTS = SB_RPORTS,
  parameter int MAXLAT = SB_MAXLAT,
  parameter int FWDWIN = FWD_WINDOW_DEFAULT,
  localparam int RW    = $clog2(NREG),
  localparam int LATW  = $clog2(MAXLAT + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic                 issue_valid,
  input  logic                 issue_wen,
  input  logic [RW-1:0]        issue_wsel,
  input  logic [LATW-1:0]      issue_lat,
  input  logic [RPORTS*RW-1:0] rsel,
  input  logic [RPORTS-1:0]    ren,
  output logic [RPORTS-1:0]    rport_hazard,
  output logic [RPORTS-1:0]    rport_fwd,
  output logic                 stall,
  output logic                 issue_accept,
  output logic                 busy
);

  localparam logic [LATW-1:0] FWD_L = LATW'(FWDWIN);
  localparam logic [LATW-1:0] MAX_L = LATW'(MAXLAT);

  // Entry 0 is the hardwired-zero register: it never has a pending write.
  logic [NREG-1:0][LATW-1:0] cnt;
  logic [LATW-1:0]           lat_eff;
  logic                      waw;
  logic                      wr_en;

  assign cnt[0] = '0;

  // Oversized latencies are clamped so a bad encoding can never wrap the counter.
  always_comb begin
    lat_eff = (issue_lat > MAX_L) ? MAX_L : issue_lat;
  end

  // Per-port RAW check against pre-update counts; same source on two ports reports identically.
  always_comb begin
    rport_hazard = '0;
    rport_fwd    = '0;
    for (int p = 0; p < RPORTS; p++) begin
      if (ren[p] && (rsel[p*RW +: RW] != '0) && (cnt[rsel[p*RW +: RW]] != '0)) begin
        rport_fwd[p]    = (cnt[rsel[p*RW +: RW]] <= FWD_L);
        rport_hazard[p] = (cnt[rsel[p*RW +: RW]] >  FWD_L);
      end
    end
  end

  // WAW: a younger, shorter write would retire before the older one still in flight.
  always_comb begin
    waw          = issue_valid && issue_wen && (issue_wsel != '0) && (cnt[issue_wsel] > lat_eff);
    stall        = issue_valid && ((|rport_hazard) || waw);
    issue_accept = issue_valid && !stall && !freeze && !flush;
    wr_en        = issue_accept && issue_wen;
    busy         = |cnt;
  end

  for (genvar i = 1; i < NREG; i++) begin : g_entry
    hazard_scoreboard_entry #(
      .W (LATW)
    ) u_entry (
      .clk      (CLK),
      .rst      (RST),
      .clr      (flush),
      .hold     (freeze),
      .load     (wr_en && (issue_wsel == RW'(i))),
      .load_val (lat_eff),
      .cnt      (cnt[i])
    );
  end

  // A writing issue must carry a latency in 1..MAXLAT.
  a_lat_range : assert property (@(posedge CLK) disable iff (RST)
    (issue_valid && issue_wen) |-> ((issue_lat != '0) && (issue_lat <= MAX_L)));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: reset, load-use, WAW, freeze, flush, r0 and ren masking.
// Latency: inputs change 1ns after the rising edge, outputs checked 1ns later.
// Backpressure: stall/issue_accept checked against hand-computed counter values.
module tb_hazard_scoreboard;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  hazard_scoreboard_if #(.NREG(32), .RPORTS(2), .MAXLAT(8)) sb_if (.CLK(CLK));

  hazard_scoreboard #(
    .NREG(32), .RPORTS(2), .MAXLAT(8), .FWDWIN(2)
  ) dut (
    .CLK          (CLK),
    .RST          (sb_if.RST),
    .freeze       (sb_if.freeze),
    .flush        (sb_if.flush),
    .issue_valid  (sb_if.issue_valid),
    .issue_wen    (sb_if.issue_wen),
    .issue_wsel   (sb_if.issue_wsel),
    .issue_lat    (sb_if.issue_lat),
    .rsel         (sb_if.rsel),
    .ren          (sb_if.ren),
    .rport_hazard (sb_if.rport_hazard),
    .rport_fwd    (sb_if.rport_fwd),
    .stall        (sb_if.stall),
    .issue_accept (sb_if.issue_accept),
    .busy         (sb_if.busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    sb_if.freeze      = 1'b0;
    sb_if.flush       = 1'b0;
    sb_if.issue_valid = 1'b0;
    sb_if.issue_wen   = 1'b0;
    sb_if.issue_wsel  = 5'd0;
    sb_if.issue_lat   = 4'd1;
    sb_if.rsel        = 10'd0;
    sb_if.ren         = 2'b00;
  endtask

  task automatic issue_wr(input logic [4:0] wsel, input logic [3:0] lat);
    sb_if.issue_valid = 1'b1;
    sb_if.issue_wen   = 1'b1;
    sb_if.issue_wsel  = wsel;
    sb_if.issue_lat   = lat;
  endtask

  initial begin
    idle();
    sb_if.RST = 1'b1;
    tick();
    tick();
    // Still in reset with idle inputs: every output low.
    check_eq("rst_stall",  32'(sb_if.stall),        32'd0);
    check_eq("rst_accept", 32'(sb_if.issue_accept), 32'd0);
    check_eq("rst_busy",   32'(sb_if.busy),         32'd0);
    sb_if.RST = 1'b0;

    // Idle read of untracked registers 5 and 6.
    sb_if.issue_valid = 1'b1;
    sb_if.rsel        = {5'd6, 5'd5};
    sb_if.ren         = 2'b11;
    settle();
    check_eq("idle_stall",  32'(sb_if.stall),        32'd0);
    check_eq("idle_accept", 32'(sb_if.issue_accept), 32'd1);
    check_eq("idle_busy",   32'(sb_if.busy),         32'd0);
    tick();

    // Load-use: r3 lat 4, then read r3 on port 0.
    idle();
    issue_wr(5'd3, 4'd4);
    settle();
    check_eq("lu_issue_accept", 32'(sb_if.issue_accept), 32'd1);
    tick();
    idle();
    sb_if.issue_valid = 1'b1;
    sb_if.rsel        = {5'd0, 5'd3};
    sb_if.ren         = 2'b01;
    settle();
    check_eq("lu_cnt4_hazard", 32'(sb_if.rport_hazard), 32'd1);
    check_eq("lu_cnt4_fwd",    32'(sb_if.rport_fwd),    32'd0);
    check_eq("lu_cnt4_stall",  32'(sb_if.stall),        32'd1);
    check_eq("lu_cnt4_busy",   32'(sb_if.busy),         32'd1);
    tick();
    check_eq("lu_cnt3_stall",  32'(sb_if.stall),        32'd1);
    tick();
    check_eq("lu_cnt2_hazard", 32'(sb_if.rport_hazard), 32'd0);
    check_eq("lu_cnt2_fwd",    32'(sb_if.rport_fwd),    32'd1);
    check_eq("lu_cnt2_stall",  32'(sb_if.stall),        32'd0);
    check_eq("lu_cnt2_accept", 32'(sb_if.issue_accept), 32'd1);
    tick();
    check_eq("lu_cnt1_fwd",    32'(sb_if.rport_fwd),    32'd1);
    tick();
    check_eq("lu_done_fwd",    32'(sb_if.rport_fwd),    32'd0);
    check_eq("lu_done_busy",   32'(sb_if.busy),         32'd0);

    // WAW: r7 lat 6, then r7 lat 2 stalls while cnt[7] is 6,5,4,3.
    idle();
    issue_wr(5'd7, 4'd6);
    tick();
    issue_wr(5'd7, 4'd2);
    for (int k = 6; k >= 3; k--) begin
      settle();
      check_eq($sformatf("waw_stall_cnt%0d", k), 32'(sb_if.stall), 32'd1);
      check_eq($sformatf("waw_cnt%0d", k), 32'(dut.cnt[7]), 32'(k));
      tick();
    end
    check_eq("waw_release_stall",  32'(sb_if.stall),        32'd0);
    check_eq("waw_release_accept", 32'(sb_if.issue_accept), 32'd1);
    tick();
    idle();
    // Load of 2 replaces the decrement that would have left 1.
    check_eq("waw_cnt_after", 32'(dut.cnt[7]), 32'd2);
    tick();
    tick();
    check_eq("waw_drained", 32'(sb_if.busy), 32'd0);

    // Freeze: r4 lat 3 then freeze 5 cycles while presenting r5.
    issue_wr(5'd4, 4'd3);
    tick();
    issue_wr(5'd5, 4'd1);
    sb_if.freeze = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      check_eq("frz_accept", 32'(sb_if.issue_accept), 32'd0);
      check_eq("frz_stall",  32'(sb_if.stall),        32'd0);
      tick();
    end
    check_eq("frz_cnt4_held", 32'(dut.cnt[4]), 32'd3);
    check_eq("frz_cnt5_none", 32'(dut.cnt[5]), 32'd0);
    idle();
    tick();
    tick();
    check_eq("frz_cnt4_1",  32'(dut.cnt[4]), 32'd1);
    check_eq("frz_busy_1",  32'(sb_if.busy), 32'd1);
    tick();
    check_eq("frz_cnt4_0",  32'(dut.cnt[4]), 32'd0);
    check_eq("frz_busy_0",  32'(sb_if.busy), 32'd0);

    // Flush: r2 lat 8, r9 lat 5, r31 lat 3 -> counts 6, 4, 3.
    issue_wr(5'd2, 4'd8);
    tick();
    issue_wr(5'd9, 4'd5);
    tick();
    issue_wr(5'd31, 4'd3);
    tick();
    idle();
    sb_if.rsel = {5'd31, 5'd31};
    sb_if.ren  = 2'b11;
    settle();
    check_eq("fl_same_reg_hazard", 32'(sb_if.rport_hazard), 32'd3);
    check_eq("fl_novalid_stall",   32'(sb_if.stall),        32'd0);
    check_eq("fl_pre_busy",        32'(sb_if.busy),         32'd1);
    idle();
    issue_wr(5'd10, 4'd4);
    sb_if.flush = 1'b1;
    settle();
    check_eq("fl_accept", 32'(sb_if.issue_accept), 32'd0);
    tick();
    idle();
    settle();
    check_eq("fl_busy",  32'(sb_if.busy),     32'd0);
    check_eq("fl_cnt10", 32'(dut.cnt[10]),    32'd0);
    check_eq("fl_cnt2",  32'(dut.cnt[2]),     32'd0);

    // Register 0 is never tracked.
    issue_wr(5'd0, 4'd5);
    settle();
    check_eq("r0_accept", 32'(sb_if.issue_accept), 32'd1);
    tick();
    idle();
    settle();
    check_eq("r0_busy", 32'(sb_if.busy), 32'd0);

    // ren masking: r3 pending (cnt 5) on port 1, port 1 disabled then enabled.
    issue_wr(5'd3, 4'd5);
    tick();
    idle();
    sb_if.issue_valid = 1'b1;
    sb_if.rsel        = {5'd3, 5'd6};
    sb_if.ren         = 2'b01;
    settle();
    check_eq("ren_off_hazard", 32'(sb_if.rport_hazard), 32'd0);
    check_eq("ren_off_stall",  32'(sb_if.stall),        32'd0);
    sb_if.ren = 2'b10;
    settle();
    check_eq("ren_on_hazard", 32'(sb_if.rport_hazard), 32'd2);
    check_eq("ren_on_stall",  32'(sb_if.stall),        32'd1);

    // Issue reading its own destination sees the older producer's count.
    idle();
    issue_wr(5'd3, 4'd1);
    sb_if.rsel = {5'd0, 5'd3};
    sb_if.ren  = 2'b01;
    settle();
    check_eq("self_rd_hazard", 32'(sb_if.rport_hazard), 32'd1);
    check_eq("self_rd_accept", 32'(sb_if.issue_accept), 32'd0);
    tick();
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
